fpa_pipe: RTL and testbench
===========================

FPA_PIPE -- requirements
Module: fpa_pipe

Interface
REQ-001 Parameter LATENCY, default 2, sets cycles from input acceptance to output valid; legal range 2..6.
REQ-002 Parameter TAG_W, default 4, sets the width of the user tag carried alongside each operation; legal range 1..16.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 Port in_valid, input, 1, operation presented on number_A/number_B/op/in_tag.
REQ-006 Port in_ready, output, 1, block accepts the presented operation this cycle.
REQ-007 Port number_A, input, 32, IEEE-754 single-precision operand A.
REQ-008 Port number_B, input, 32, IEEE-754 single-precision operand B.
REQ-009 Port op, input, 1, 0 = A+B, 1 = A-B.
REQ-010 Port in_tag, input, TAG_W, user tag returned with the result.
REQ-011 Port out_valid, output, 1, number_out/out_tag/flags hold a valid result.
REQ-012 Port out_ready, input, 1, downstream consumes the result this cycle.
REQ-013 Port number_out, output, 32, single-precision result.
REQ-014 Port out_tag, output, TAG_W, tag of the operation producing number_out.
REQ-015 Port flags, output, 3, {nan, inf, zero} classification of number_out.

Function
REQ-016 Arithmetic SHALL be performed by one instance of the existing combinational fpa adder (number_A, number_B -> number_out).
REQ-017 Subtraction SHALL be realised by inverting bit 31 of number_B before it enters the input register; no other operand modification.
REQ-018 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-019 Structure: one input register stage (A, B', tag, valid) feeding fpa, then LATENCY-1 register stages after fpa carrying result, tag, flags, valid.
REQ-020 Stall: stall = out_valid && !out_ready; while stall, every stage (data and valid) SHALL hold its value.
REQ-021 in_ready SHALL equal !stall (combinational from out_valid and out_ready; no dependence on in_valid).
REQ-022 When not stalled, every stage SHALL advance one position per cycle; an empty slot (valid=0) advances as a bubble; bubbles are not collapsed.
REQ-023 Latency: an operation accepted at edge N with no stalls SHALL present out_valid=1 with its result after edge N+LATENCY-1; each stall cycle adds exactly one cycle.
REQ-024 Throughput: one operation per cycle when out_ready is held 1.
REQ-025 Ordering: results SHALL leave in acceptance order with their own tags; no operation lost or duplicated.
REQ-026 flags SHALL be computed from the fpa result before the first post-fpa register: nan = exp==0xFF && mant!=0; inf = exp==0xFF && mant==0; zero = exp==0x00 && mant==0 (either sign); at most one bit set.
REQ-027 Stage registers whose valid bit is 0 MAY hold stale data; only out_valid qualifies number_out/out_tag/flags.
REQ-028 Simultaneous accept and emit in the same cycle SHALL both complete (pipeline advances, new operation enters).
REQ-029 in_valid=0 with in_ready=1 SHALL insert a bubble at the input stage.

Reset
REQ-030 While rst_n=0 at a rising edge, all stage valid bits SHALL clear; out_valid=0 after that edge, hence in_ready=1.
REQ-031 number_out, out_tag, flags SHALL reset to 0.
REQ-032 Reset mid-operation SHALL discard all in-flight operations; none emerges after rst_n returns high.
REQ-033 Operations presented while rst_n=0 SHALL NOT be accepted.

Verification
REQ-034 LATENCY=2, out_ready=1: A=0x3F800000, B=0x40000000, op=0, tag=3 at edge N -> out_valid=1 after edge N+1, number_out=0x40400000, out_tag=3, flags=000.
REQ-035 op=1, A=0x40400000, B=0x3F800000 -> number_out=0x40000000; A=B=0x3F800000, op=1 -> number_out zero, flags=001.
REQ-036 LATENCY=4, stream 8 back-to-back ops tags 0..7, out_ready=1 -> first result after 3 edges, then one per cycle, tags 0..7 in order.
REQ-037 Hold out_ready=0 for 5 cycles with pipe full -> in_ready=0, number_out/out_tag stable; release -> remaining results in order, none lost/duplicated.
REQ-038 Assert rst_n=0 for one edge with 3 ops in flight -> out_valid=0, outputs 0, in_ready=1; no stale result appears over the next LATENCY+2 cycles.
REQ-039 A=0x7F800000, B=0x3F800000, op=0 -> flags=010; A=0x7FC00000 -> flags=100.

Source files
------------

// File: rtl/fpa_pipe.sv
// fpa: combinational IEEE-754 single-precision adder, round-to-nearest-even, subnormals kept.
// NaN inputs propagate quietened; inf - inf yields the canonical quiet NaN 0x7FC00000.
module fpa (
  input  logic [31:0] number_A,
  input  logic [31:0] number_B,
  output logic [31:0] number_out
);
  logic        big_a, sx, sub, rup, a_nan, b_nan, a_inf, b_inf;
  logic [7:0]  ex_r, ey_r;
  logic [23:0] mx, my;
  logic [9:0]  ex, ey, d, sh, e;
  logic [26:0] ax, ay, al, mask, n;
  logic [27:0] s;
  logic [24:0] r;

  always_comb begin
    a_nan = (number_A[30:23] == 8'hFF) && (number_A[22:0] != 23'd0);
    b_nan = (number_B[30:23] == 8'hFF) && (number_B[22:0] != 23'd0);
    a_inf = (number_A[30:23] == 8'hFF) && (number_A[22:0] == 23'd0);
    b_inf = (number_B[30:23] == 8'hFF) && (number_B[22:0] == 23'd0);
    sub   = number_A[31] ^ number_B[31];

    // Order by magnitude so the subtraction below never goes negative.
    big_a = number_A[30:0] >= number_B[30:0];
    sx    = big_a ? number_A[31] : number_B[31];
    ex_r  = big_a ? number_A[30:23] : number_B[30:23];
    ey_r  = big_a ? number_B[30:23] : number_A[30:23];
    mx    = {ex_r != 8'd0, big_a ? number_A[22:0] : number_B[22:0]};
    my    = {ey_r != 8'd0, big_a ? number_B[22:0] : number_A[22:0]};
    ex    = (ex_r == 8'd0) ? 10'd1 : {2'b00, ex_r};
    ey    = (ey_r == 8'd0) ? 10'd1 : {2'b00, ey_r};
    d     = ex - ey;

    // Three extra LSBs hold guard, round and sticky.
    ax   = {mx, 3'b000};
    ay   = {my, 3'b000};
    mask = '0;
    if (d >= 10'd27) begin
      al = {26'd0, |my};
    end else begin
      mask = (27'd1 << d) - 27'd1;
      al   = (ay >> d) | {26'd0, |(ay & mask)};
    end
    s = sub ? ({1'b0, ax} - {1'b0, al}) : ({1'b0, ax} + {1'b0, al});

    sh = 10'd27;
    if (s[27]) begin
      n = s[27:1] | {26'd0, s[0]};
      e = ex + 10'd1;
    end else begin
      for (int i = 0; i < 27; i++) begin
        if (s[i]) sh = 10'(26 - i);
      end
      // Never normalise below the minimum exponent; what is left is subnormal.
      if (sh > ex - 10'd1) sh = ex - 10'd1;
      n = s[26:0] << sh;
      e = n[26] ? (ex - sh) : 10'd0;
    end

    rup = n[2] & (n[1] | n[0] | n[3]);
    r   = {1'b0, n[26:3]} + {24'd0, rup};
    if (r[24])                     e = e + 10'd1;
    else if (e == 10'd0 && r[23])  e = 10'd1;

    if (a_nan)                      number_out = number_A | 32'h0040_0000;
    else if (b_nan)                 number_out = number_B | 32'h0040_0000;
    else if (a_inf && b_inf && sub) number_out = 32'h7FC0_0000;
    else if (a_inf)                 number_out = number_A;
    else if (b_inf)                 number_out = number_B;
    else if (s == 28'd0)            number_out = {number_A[31] & number_B[31], 31'd0};
    else if (e >= 10'd255)          number_out = {sx, 8'hFF, 23'd0};
    else                            number_out = {sx, e[7:0], r[22:0]};
  end
endmodule

// fpa_pipe: tagged add/sub around fpa; LATENCY cycles from acceptance to out_valid.
// Whole pipe freezes while a result waits on out_ready; in_ready = !stall, bubbles are kept.
module fpa_pipe #(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      number_A,
  input  logic [31:0]      number_B,
  input  logic             op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      number_out,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       flags
);
  localparam int NP = LATENCY - 1;

  logic             stall, v_q;
  logic [31:0]      a_q, b_q, sum;
  logic [TAG_W-1:0] tag_q;
  logic [2:0]       sum_flags;
  logic [31:0]      res_q  [NP];
  logic [TAG_W-1:0] rtag_q [NP];
  logic [2:0]       rflg_q [NP];
  logic [NP-1:0]    rv_q;

  assign stall      = rv_q[NP-1] && !out_ready;
  assign in_ready   = !stall;
  assign out_valid  = rv_q[NP-1];
  assign number_out = res_q[NP-1];
  assign out_tag    = rtag_q[NP-1];
  assign flags      = rflg_q[NP-1];

  fpa u_fpa (.number_A(a_q), .number_B(b_q), .number_out(sum));

  always_comb begin
    sum_flags = 3'b000;
    if (sum[30:23] == 8'hFF)      sum_flags = (sum[22:0] != 23'd0) ? 3'b100 : 3'b010;
    else if (sum[30:0] == 31'd0)  sum_flags = 3'b001;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
      rv_q  <= '0;
      for (int i = 0; i < NP; i++) begin
        res_q[i]  <= '0;
        rtag_q[i] <= '0;
        rflg_q[i] <= '0;
      end
    end else if (!stall) begin
      v_q      <= in_valid;
      a_q      <= number_A;
      b_q      <= {number_B[31] ^ op, number_B[30:0]};
      tag_q    <= in_tag;
      rv_q[0]  <= v_q;
      res_q[0] <= sum;
      rtag_q[0] <= tag_q;
      rflg_q[0] <= sum_flags;
      for (int i = 1; i < NP; i++) begin
        rv_q[i]   <= rv_q[i-1];
        res_q[i]  <= res_q[i-1];
        rtag_q[i] <= rtag_q[i-1];
        rflg_q[i] <= rflg_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_fpa_pipe.sv
// Bench for fpa_pipe: LATENCY=2 and LATENCY=4 instances share stimulus, sel picks which one receives it.
module tb_fpa_pipe;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    logic [3:0]  tag;
    int          acc;
    int          sc;
  } exp_t;

  logic        clk, rst_n, in_valid, sel, op, out_ready;
  logic [31:0] number_A, number_B;
  logic [3:0]  in_tag;
  logic        ir2, ov2, ir4, ov4;
  logic [31:0] nout2, nout4;
  logic [3:0]  otag2, otag4;
  logic [2:0]  fl2, fl4;
  logic        iv2, iv4;

  logic        ov [2], ir [2], iv [2];
  logic [31:0] no [2];
  logic [3:0]  ot [2];
  logic [2:0]  fl [2];

  vec_t        vt [14];
  exp_t        sbq [2][$];
  exp_t        pe;
  logic [31:0] cur_res;
  logic [2:0]  cur_flg;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stalls [2] = '{0, 0};
  int          emitted [2] = '{0, 0};
  int          lat [2] = '{2, 4};

  assign iv2 = in_valid & ~sel;
  assign iv4 = in_valid & sel;
  assign ov[0] = ov2;   assign ov[1] = ov4;
  assign ir[0] = ir2;   assign ir[1] = ir4;
  assign iv[0] = iv2;   assign iv[1] = iv4;
  assign no[0] = nout2; assign no[1] = nout4;
  assign ot[0] = otag2; assign ot[1] = otag4;
  assign fl[0] = fl2;   assign fl[1] = fl4;

  fpa_pipe #(.LATENCY(2), .TAG_W(4)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .number_A(number_A), .number_B(number_B), .op(op), .in_tag(in_tag),
    .out_valid(ov2), .out_ready(out_ready), .number_out(nout2), .out_tag(otag2), .flags(fl2)
  );

  fpa_pipe #(.LATENCY(4), .TAG_W(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .number_A(number_A), .number_B(number_B), .op(op), .in_tag(in_tag),
    .out_valid(ov4), .out_ready(out_ready), .number_out(nout4), .out_tag(otag4), .flags(fl4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on emit; latency accounts for every stall cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        sbq[d].delete();
      end else begin
        if (ov[d] && !out_ready) stalls[d]++;
        if (iv[d] && ir[d]) sbq[d].push_back('{cur_res, cur_flg, in_tag, cyc + 1, stalls[d]});
        if (ov[d] && out_ready) begin
          emitted[d]++;
          chk("sb_expected", 32'(sbq[d].size() > 0), 32'd1);
          if (sbq[d].size() > 0) begin
            pe = sbq[d].pop_front();
            chk("result", no[d], pe.res);
            chk("tag", 32'(ot[d]), 32'(pe.tag));
            chk("flags", 32'(fl[d]), 32'(pe.flg));
            chk("latency", 32'(cyc - pe.acc), 32'(lat[d] - 1 + stalls[d] - pe.sc));
          end
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [3:0] t);
    number_A = vt[i].a;
    number_B = vt[i].b;
    op       = vt[i].op;
    in_tag   = t;
    cur_res  = vt[i].res;
    cur_flg  = vt[i].flg;
    in_valid = 1'b1;
  endtask

  task automatic send(input int i, input logic [3:0] t);
    logic acc;
    int   n;
    set_op(i, t);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = sel ? ir4 : ir2;
      n++;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (sbq[d].size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(sbq[d].size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_res;
    logic [3:0]  hold_tag;
    int          base;

    vt[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
    vt[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000};
    vt[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b001};
    vt[3]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b010};
    vt[4]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100};
    vt[5]  = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b001};
    vt[6]  = '{32'h40A00000, 32'h41200000, 1'b1, 32'hC0A00000, 3'b000};
    vt[7]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010};
    vt[8]  = '{32'hFF800000, 32'h7F800000, 1'b0, 32'h7FC00000, 3'b100};
    vt[9]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000};
    vt[10] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000};
    vt[11] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000};
    vt[12] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b001};
    vt[13] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b001};

    rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; op = 1'b0; out_ready = 1'b1;
    number_A = '0; number_B = '0; in_tag = '0; cur_res = '0; cur_flg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov2", 32'(ov2), 32'd0);
    chk("rst_nout2", nout2, 32'd0);
    chk("rst_tag2", 32'(otag2), 32'd0);
    chk("rst_flags2", 32'(fl2), 32'd0);
    chk("rst_ir2", 32'(ir2), 32'd1);
    chk("rst_ov4", 32'(ov4), 32'd0);
    chk("rst_nout4", nout4, 32'd0);
    chk("rst_ir4", 32'(ir4), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single 1.0 + 2.0 on the LATENCY=2 pipe with explicit edge timing.
    set_op(0, 4'd3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("l2_not_yet", 32'(ov2), 32'd0);
    @(posedge clk);
    #1;
    chk("l2_valid", 32'(ov2), 32'd1);
    chk("l2_sum", nout2, 32'h40400000);
    chk("l2_tag", 32'(otag2), 32'd3);
    chk("l2_flags", 32'(fl2), 32'd0);
    @(posedge clk);
    #1;

    // Whole vector table back-to-back through LATENCY=2.
    for (int i = 0; i < 14; i++) send(i, 4'(i));
    in_valid = 1'b0;
    drain(0);

    // Eight back-to-back ops, tags 0..7, through LATENCY=4.
    sel  = 1'b1;
    base = emitted[1];
    for (int i = 0; i < 8; i++) send(i, 4'(i));
    in_valid = 1'b0;
    drain(1);
    chk("l4_count", 32'(emitted[1] - base), 32'd8);

    // Fill LATENCY=4 with out_ready low, then hold a stall for 5 cycles.
    out_ready = 1'b0;
    base = emitted[1];
    for (int i = 0; i < 4; i++) send(i + 4, 4'(8 + i));
    chk("full_ov", 32'(ov4), 32'd1);
    chk("full_ir", 32'(ir4), 32'd0);
    set_op(8, 4'd12);
    hold_res = nout4;
    hold_tag = otag4;
    repeat (5) begin
      @(negedge clk);
      chk("stall_ir", 32'(ir4), 32'd0);
      chk("stall_res", nout4, hold_res);
      chk("stall_tag", 32'(otag4), 32'(hold_tag));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8 + i, 4'(12 + i));
    in_valid = 1'b0;
    drain(1);
    chk("stall_count", 32'(emitted[1] - base), 32'd8);

    // Reset with three ops in flight; an op presented during reset must not enter.
    for (int i = 0; i < 3; i++) send(i, 4'(i + 1));
    rst_n = 1'b0;
    set_op(3, 4'd9);
    @(posedge clk);
    #1;
    chk("mid_rst_ov", 32'(ov4), 32'd0);
    chk("mid_rst_nout", nout4, 32'd0);
    chk("mid_rst_tag", 32'(otag4), 32'd0);
    chk("mid_rst_flags", 32'(fl4), 32'd0);
    chk("mid_rst_ir", 32'(ir4), 32'd1);
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale", 32'(ov4), 32'd0);
    end
    chk("rst_sb_empty", 32'(sbq[1].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
